// File: rtl/mux5_rr_sequencer_if.sv
// Bus between the round-robin sequencer, its five requesters, the external
// 5:1 mux and the downstream consumer of the captured beats.
interface mux5_rr_sequencer_if #(
  parameter int N = 32
);
  logic [4:0]   req;
  logic [N-1:0] mux_out;
  logic [2:0]   sel;
  logic [4:0]   gnt;
  logic [4:0]   ack;
  logic [N-1:0] out_data;
  logic         out_valid;
  logic         out_ready;

  // Requesters / mux / consumer side.
  modport master (
    output req, mux_out, out_ready,
    input  sel, gnt, ack, out_data, out_valid
  );

  // Sequencer side.
  modport slave (
    input  req, mux_out, out_ready,
    output sel, gnt, ack, out_data, out_valid
  );
endinterface

// File: rtl/mux5_rr_sequencer.sv
// Round-robin sequencer sharing one external 5:1 mux between five requesters.
// A grant is held for up to MAX_BURST beats; each beat copies the mux output
// into a one-entry valid/ready output register. Priority rotates past the
// last grantee, and every release costs one idle cycle before the next grant.
module mux5_rr_sequencer #(
  parameter int N         = 32,
  parameter int MAX_BURST = 4
) (
  input logic                clk,
  input logic                rst,
  mux5_rr_sequencer_if.slave bus
);

  localparam int                CNT_W     = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state, state_nxt;
  logic [4:0]       grant, grant_nxt;
  logic [2:0]       sel_idx, sel_nxt;
  logic [2:0]       last, last_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [N-1:0]     data_p1;
  logic             vld_p1;
  logic             slot_free;
  logic             req_held;
  logic             beat;
  logic             final_beat;
  logic [2:0]       winner;

  // First requester after 'from' in rotating order; 'from' itself is checked
  // last. Scanning from the farthest offset down lets the nearest one win.
  function automatic logic [2:0] next_winner(input logic [4:0] r, input logic [2:0] from);
    logic [2:0] pick;
    logic [3:0] idx;
    pick = from;
    for (int i = 5; i >= 1; i--) begin
      idx = {1'b0, from} + 4'(i);
      if (idx >= 4'd5) idx = idx - 4'd5;
      if (r[idx[2:0]]) pick = idx[2:0];
    end
    return pick;
  endfunction

  assign slot_free  = !vld_p1 || bus.out_ready;
  assign req_held   = |(bus.req & grant);
  assign beat       = !rst && (state == BUSY) && req_held && slot_free;
  assign final_beat = beat && ((cnt + CNT_ONE) == LAST_BEAT);
  assign winner     = next_winner(bus.req, last);

  assign bus.ack       = beat ? grant : 5'd0;
  assign bus.gnt       = grant;
  assign bus.sel       = sel_idx;
  assign bus.out_data  = data_p1;
  assign bus.out_valid = vld_p1;

  // Next-state logic: arbitrate when idle, count beats and decide release when busy.
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    sel_nxt   = sel_idx;
    last_nxt  = last;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (|bus.req) begin
          state_nxt = BUSY;
          grant_nxt = 5'b00001 << winner;
          sel_nxt   = winner;
          cnt_nxt   = '0;
        end
      end
      BUSY: begin
        if (beat) cnt_nxt = cnt + CNT_ONE;
        if (!req_held || final_beat) begin
          state_nxt = IDLE;
          grant_nxt = '0;
          last_nxt  = sel_idx;
          cnt_nxt   = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Arbitration state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      grant   <= '0;
      sel_idx <= 3'd0;
      last    <= 3'd4;
      cnt     <= '0;
    end else begin
      state   <= state_nxt;
      grant   <= grant_nxt;
      sel_idx <= sel_nxt;
      last    <= last_nxt;
      cnt     <= cnt_nxt;
    end
  end

  // Stage p1: capture the selected mux input; a beat may refill the slot
  // in the same cycle the previous beat is consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
    end else if (beat) begin
      data_p1 <= bus.mux_out;
      vld_p1  <= 1'b1;
    end else if (vld_p1 && bus.out_ready) begin
      vld_p1  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux5_rr_sequencer.sv
// Bench for mux5_rr_sequencer: two instances (MAX_BURST=4 and MAX_BURST=1)
// share one stimulus stream. A behavioural arbiter model predicts every
// output each cycle; directed literal values pin the key scenarios.
module tb_mux5_rr_sequencer;

  localparam int MB0 = 4;
  localparam int MB1 = 1;
  localparam int F_GNT  = 0;
  localparam int F_SEL  = 1;
  localparam int F_ACK  = 2;
  localparam int F_VLD  = 3;
  localparam int F_DATA = 4;

  typedef struct {
    string       name;
    int          inst;
    int          field;
    logic [31:0] val;
  } pin_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] req;
  logic       out_ready;
  bit         chk_en = 1'b0;

  // Per-instance requester data; each requester advances its word after every acked beat.
  logic [31:0] rdata [2][8];

  // Behavioural model state (grantee -1 means nobody holds the mux).
  int          m_gr    [2];
  int          m_sel   [2];
  int          m_last  [2];
  int          m_beats [2];
  bit          m_valid [2];
  logic [31:0] m_data  [2];

  pin_t pin_buf [128];
  int   wr_ptr = 0;
  int   rd_ptr = 0;
  int   n_cmp  = 0;
  int   n_bad  = 0;

  mux5_rr_sequencer_if #(.N(32)) bus0 ();
  mux5_rr_sequencer_if #(.N(32)) bus1 ();

  assign bus0.req       = req;
  assign bus1.req       = req;
  assign bus0.out_ready = out_ready;
  assign bus1.out_ready = out_ready;
  assign bus0.mux_out   = (bus0.sel <= 3'd4) ? rdata[0][bus0.sel] : 32'hDEADBEEF;
  assign bus1.mux_out   = (bus1.sel <= 3'd4) ? rdata[1][bus1.sel] : 32'hDEADBEEF;

  mux5_rr_sequencer #(.N(32), .MAX_BURST(MB0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  mux5_rr_sequencer #(.N(32), .MAX_BURST(MB1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  always #5 clk = ~clk;

  function automatic logic [31:0] exp_gnt(input int i);
    return (m_gr[i] < 0) ? 32'd0 : (32'd1 << m_gr[i]);
  endfunction

  function automatic logic [31:0] exp_ack(input int i);
    if (rst || m_gr[i] < 0) return 32'd0;
    if (req[m_gr[i]] && (!m_valid[i] || out_ready)) return 32'd1 << m_gr[i];
    return 32'd0;
  endfunction

  function automatic logic [31:0] act(input int i, input int field);
    logic [31:0] v;
    v = 'x;
    case (field)
      F_GNT:  v = (i == 0) ? 32'(bus0.gnt)       : 32'(bus1.gnt);
      F_SEL:  v = (i == 0) ? 32'(bus0.sel)       : 32'(bus1.sel);
      F_ACK:  v = (i == 0) ? 32'(bus0.ack)       : 32'(bus1.ack);
      F_VLD:  v = (i == 0) ? 32'(bus0.out_valid) : 32'(bus1.out_valid);
      F_DATA: v = (i == 0) ? bus0.out_data       : bus1.out_data;
      default: v = 'x;
    endcase
    return v;
  endfunction

  // Model: arbitration, burst counting and the output slot, advanced on each rising edge.
  always @(posedge clk) begin
    int  g;
    int  w;
    bit  found;
    bit  slot;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_gr[i] = -1; m_sel[i] = 0; m_last[i] = 4; m_beats[i] = 0;
        m_valid[i] = 1'b0; m_data[i] = 32'd0;
        for (int k = 0; k < 5; k++) rdata[i][k] <= 32'hA0 + (32'(k) << 8);
      end else begin
        slot = !m_valid[i] || out_ready;
        if (m_gr[i] < 0) begin
          if (m_valid[i] && out_ready) m_valid[i] = 1'b0;
          found = 1'b0; w = 0;
          for (int d = 1; d <= 5; d++) begin
            if (!found && req[(m_last[i] + d) % 5]) begin
              found = 1'b1;
              w = (m_last[i] + d) % 5;
            end
          end
          if (found) begin
            m_gr[i] = w; m_sel[i] = w; m_beats[i] = 0;
          end
        end else begin
          g = m_gr[i];
          if (req[g] && slot) begin
            m_data[i]  = rdata[i][g];
            m_valid[i] = 1'b1;
            rdata[i][g] <= rdata[i][g] + 32'd1;
            m_beats[i] = m_beats[i] + 1;
            if (m_beats[i] == ((i == 0) ? MB0 : MB1)) begin
              m_last[i] = g; m_gr[i] = -1;
            end
          end else begin
            if (m_valid[i] && out_ready) m_valid[i] = 1'b0;
            if (!req[g]) begin
              m_last[i] = g; m_gr[i] = -1;
            end
          end
        end
      end
    end
  end

  task automatic cmp(input string name, input int inst, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s inst%0d t=%0t: got %h expected %h", name, inst, $time, a, e);
    end
  endtask

  // Compare process: model versus both DUTs every cycle, then any pinned literals.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        cmp("gnt",       i, act(i, F_GNT),  exp_gnt(i));
        cmp("sel",       i, act(i, F_SEL),  32'(m_sel[i]));
        cmp("ack",       i, act(i, F_ACK),  exp_ack(i));
        cmp("out_valid", i, act(i, F_VLD),  32'(m_valid[i]));
        cmp("out_data",  i, act(i, F_DATA), m_data[i]);
      end
      while (rd_ptr != wr_ptr) begin
        cmp(pin_buf[rd_ptr % 128].name, pin_buf[rd_ptr % 128].inst,
            act(pin_buf[rd_ptr % 128].inst, pin_buf[rd_ptr % 128].field),
            pin_buf[rd_ptr % 128].val);
        rd_ptr++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pin(input string name, input int inst, input int field, input logic [31:0] val);
    pin_buf[wr_ptr % 128] = '{name: name, inst: inst, field: field, val: val};
    wr_ptr++;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 5'b0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic [39:0] pat;
    pat = 40'hF35AC70E9B;
    rst = 1'b1; req = 5'b0; out_ready = 1'b1;
    step(); step();
    chk_en = 1'b1;

    // 1: single requester, 4-beat burst, bubble, regrant
    pin("rst_gnt", 0, F_GNT, 0); pin("rst_sel", 0, F_SEL, 0);
    pin("rst_vld", 0, F_VLD, 0); pin("rst_data", 0, F_DATA, 0);
    rst = 1'b0; req = 5'b00001;
    pin("s1_idle_ack", 0, F_ACK, 0);
    step();
    pin("s1_gnt", 0, F_GNT, 32'h1); pin("s1_sel", 0, F_SEL, 0); pin("s1_ack", 0, F_ACK, 32'h1);
    step();
    pin("s1_beat1", 0, F_DATA, 32'hA0); pin("s1_vld1", 0, F_VLD, 1);
    step(); step(); step();
    pin("s1_rel_gnt", 0, F_GNT, 0); pin("s1_rel_ack", 0, F_ACK, 0);
    pin("s1_beat4", 0, F_DATA, 32'hA3); pin("s1_vld4", 0, F_VLD, 1);
    step();
    pin("s1_regrant", 0, F_GNT, 32'h1); pin("s1_drain", 0, F_VLD, 0);
    req = 5'b0;
    step(); step(); step();

    // 2: all requesting, rotation 0..4,0
    do_reset();
    req = 5'b11111;
    step();
    for (int g = 0; g < 6; g++) begin
      pin($sformatf("s2_gnt%0d", g), 0, F_GNT, 32'd1 << (g % 5));
      pin($sformatf("s2_sel%0d", g), 0, F_SEL, 32'(g % 5));
      repeat (5) step();
    end
    req = 5'b0;
    step(); step();

    // 3a: no preemption of requester 2 by requester 3
    do_reset();
    req = 5'b00100;
    step(); step();
    req = 5'b01100;
    step(); step();
    pin("s3_hold", 0, F_GNT, 32'h4);
    step();
    pin("s3_rel", 0, F_GNT, 0);
    step();
    pin("s3_next_gnt", 0, F_GNT, 32'h8); pin("s3_next_sel", 0, F_SEL, 3);
    req = 5'b0;
    step(); step();

    // 3b: requester 2 withdraws after two beats; last=2 makes 3 beat 0
    do_reset();
    req = 5'b00100;
    step(); step(); step();
    req = 5'b01001;
    pin("s3_drop_ack", 0, F_ACK, 0);
    step();
    pin("s3_drop_gnt", 0, F_GNT, 0); pin("s3_drop_data", 0, F_DATA, 32'h2A1);
    step();
    pin("s3_last2", 0, F_GNT, 32'h8);
    req = 5'b0;
    step(); step();

    // 4: stalled output slot freezes the burst
    do_reset();
    req = 5'b00001; out_ready = 1'b1;
    step(); step();
    out_ready = 1'b0;
    pin("s4_stall_ack", 0, F_ACK, 0);
    step(); step();
    pin("s4_stall_gnt", 0, F_GNT, 32'h1); pin("s4_stall_data", 0, F_DATA, 32'hA0);
    pin("s4_stall_vld", 0, F_VLD, 1);
    out_ready = 1'b1;
    pin("s4_resume_ack", 0, F_ACK, 32'h1);
    step();
    pin("s4_reload_data", 0, F_DATA, 32'hA1); pin("s4_reload_vld", 0, F_VLD, 1);
    step(); step();
    req = 5'b0;
    step(); step();

    // 5: reset in mid-burst
    do_reset();
    req = 5'b01000;
    step(); step(); step();
    pin("s5_pre_sel", 0, F_SEL, 3); pin("s5_pre_vld", 0, F_VLD, 1);
    rst = 1'b1;
    pin("s5_rst_ack", 0, F_ACK, 0);
    step();
    rst = 1'b0; req = 5'b10000;
    pin("s5_gnt", 0, F_GNT, 0); pin("s5_sel", 0, F_SEL, 0);
    pin("s5_vld", 0, F_VLD, 0); pin("s5_data", 0, F_DATA, 0);
    step();
    pin("s5_only4_gnt", 0, F_GNT, 32'h10); pin("s5_only4_sel", 0, F_SEL, 4);
    do_reset();
    req = 5'b10001;
    step();
    pin("s5_zero_wins", 0, F_GNT, 32'h1);
    req = 5'b0;
    step(); step();

    // 6: single-beat grants alternate between 1 and 2
    do_reset();
    req = 5'b00110;
    step();
    for (int g = 0; g < 4; g++) begin
      pin($sformatf("s6_gnt%0d", g), 1, F_GNT, (g % 2 == 0) ? 32'h2 : 32'h4);
      step();
      if (g == 0) pin("s6_data", 1, F_DATA, 32'h1A0);
      pin($sformatf("s6_bubble%0d", g), 1, F_GNT, 0);
      step();
    end
    req = 5'b0;
    step(); step();

    // 7: mixed backpressure and changing request sets, model-checked
    do_reset();
    req = 5'b11111;
    for (int c = 0; c < 40; c++) begin
      out_ready = pat[c];
      if (c == 15) req = 5'b10101;
      if (c == 30) req = 5'b01010;
      step();
    end
    out_ready = 1'b1; req = 5'b0;
    step(); step();

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
